uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
// - Shares the single TX channel of uart_rx_tx between N requesters; round-robin, frame-burst granularity.
// - Drives per-requester frame format (cr_pbit/cr_sbit/cr_ptype) into the UART.
// - Format changes only while the UART is idle. Baud settings are outside this block.
// PARAMETERS
// - N_REQ    4  number of requesters (2..8)
// - HOLDOFF  2  cycles after a tx_valid_o pulse during which tx_ready_i is ignored (1..15)
// - MAX_BURST 16 bytes per grant before forced release (used only with UART_ARB_BURST_LIMIT_EN)
// PORTS
// - clk         in  1        system clock
// - reset       in  1        synchronous, active-high reset
// - req_data_i  in  8*N_REQ  byte from requester i = [8*i+7:8*i]
// - req_valid_i in  N_REQ    requester i has a byte
// - req_last_i  in  N_REQ    byte is last of requester i's burst
// - req_cfg_i   in  4*N_REQ  requester i format {ptype,pbit,sbit[1:0]} = [4*i+3:4*i]
// - req_ready_o out N_REQ    byte of requester i accepted this cycle
// - tx_data_o   out 8        to UART tx_data_i
// - tx_valid_o  out 1        to UART tx_valid_i; one-cycle pulse
// - tx_ready_i  in  1        from UART tx_ready_o; 1 = TX idle
// - cr_pbit_o   out 1        to UART cr_pbit
// - cr_sbit_o   out 2        to UART cr_sbit
// - cr_ptype_o  out 1        to UART cr_ptype
// - grant_o     out N_REQ    one-hot current owner; 0 when none
// - busy_o      out 1        1 in any state except IDLE
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; RR pointer 0; holdoff counter 0.
// - Reset mid-burst: tx_valid_o and grant_o are 0 from the next edge. The UART frame already in flight is not aborted.
// - FSM states: IDLE, CFG, XFER, HOLD, RELEASE.
// - IDLE:
//   - Waits until any req_valid_i=1 and tx_ready_i=1 and holdoff=0.
//   - Picks the first valid requester scanning from ptr upward, wrapping at N_REQ-1 to 0.
//   - Registers grant_o.
//   - Next state is CFG if req_cfg_i[g] differs from the cr_* outputs, else XFER.
// - CFG: loads cr_* from req_cfg_i[g] (registered), stays exactly 1 cycle, then goes to XFER.
// - XFER:
//   - req_ready_o[g] = req_valid_i[g] & tx_ready_i (combinational); all other ready bits are 0.
//   - On accept: tx_data_o <= req_data_i[g], tx_valid_o <= 1 for one cycle.
//   - Also on accept: holdoff <= HOLDOFF, last_q <= req_last_i[g], then go to HOLD.
//   - Latency from accept to tx_valid_o is 1 cycle.
// - HOLD:
//   - Counts holdoff down to 0, then waits for tx_ready_i=1.
//   - Then goes to RELEASE if last_q, else XFER.
// - RELEASE:
//   - grant_o <= 0; ptr <= g+1 (mod N_REQ).
//   - Next state is IDLE. Format is not reset; it stays at the last value.
// - Grant lock: once granted, a requester keeps the grant until it sends its last byte, even if its valid drops.
// - At most one byte is accepted per UART frame. A second byte is never accepted while tx_ready_i=0 or holdoff!=0.
// - Simultaneous requests: the lowest index at or above ptr wins; all others wait. No starvation across bursts.
// - req_cfg_i is sampled only in IDLE at grant. Changes during a burst are ignored until the next grant.
// - cr_* outputs change only in CFG, which is entered only with tx_ready_i=1 and holdoff=0 (UART idle).
// CONFIGURATION
// - UART_ARB_BURST_LIMIT_EN defined:
//   - A per-grant byte counter (reset to 0 at grant) forces last_q=1 on the MAX_BURST-th accepted byte.
//   - The requester is re-arbitrated normally afterwards.
// - UART_ARB_BURST_LIMIT_EN undefined: no counter; the grant is held until req_last_i. MAX_BURST is unused.
// TESTING
// - Reset, then req0 sends 3 bytes 0x11,0x22,0x33(last) with cfg 4'b0000
//   -> no CFG cycle; 3 tx_valid_o pulses in order; grant_o=0001 then 0; busy_o=0 at end.
// - req0 and req2 valid in the same cycle, ptr=0, 1-byte bursts
//   -> req0 served first, then req2; then req0 again before req2 (alternation over 4 bursts).
// - req1 with cfg 4'b1101 after a 4'b0000 burst
//   -> exactly one CFG cycle; cr_ptype=1, cr_pbit=1, cr_sbit=01 stable before the first tx_valid_o.
//   -> the loopback UART receives the byte without rx_pbit_error.
// - req1 holds valid with bytes 0x00..0xFF over loopback
//   -> each received byte equals the sent byte; tx_valid_o never pulses while tx_ready_i=0.
// - reset asserted mid-burst after the 2nd of 5 bytes
//   -> next cycle tx_valid_o=0, grant_o=0, req_ready_o=0, ptr=0; the remaining 3 bytes are not sent.
// - With UART_ARB_BURST_LIMIT_EN, MAX_BURST=4, req0 sends 10 bytes without last and req3 is waiting
//   -> req0 4 bytes, req3 burst, then req0 resumes.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX channel between N_REQ requesters, one burst per grant.
// Define UART_ARB_BURST_LIMIT_EN to force a release after MAX_BURST bytes in a single grant.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int HOLDOFF   = 2,
  parameter int MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [N_REQ-1:0]   req_last_i,
  input  logic [4*N_REQ-1:0] req_cfg_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [7:0]         tx_data_o,
  output logic               tx_valid_o,
  input  logic               tx_ready_i,
  output logic               cr_pbit_o,
  output logic [1:0]         cr_sbit_o,
  output logic               cr_ptype_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic               busy_o
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_XFER, S_HOLD, S_RELEASE} state_t;

  state_t             state_q;
  logic [PW-1:0]      ptr_q;
  logic [PW-1:0]      gidx_q;
  logic [N_REQ-1:0]   grant_q;
  logic [7:0]         tx_data_q;
  logic               tx_valid_q;
  logic [3:0]         cfg_q;
  logic [3:0]         cr_q;
  logic [3:0]         holdoff_q;
  logic               last_q;

  logic [7:0]         data_arr [N_REQ];
  logic [3:0]         cfg_arr  [N_REQ];
  logic               win_found;
  logic [PW-1:0]      win_idx;
  logic               accept;
  logic               burst_hit;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
    assign data_arr[gi]    = req_data_i[8*gi +: 8];
    assign cfg_arr[gi]     = req_cfg_i[4*gi +: 4];
    assign req_ready_o[gi] = (state_q == S_XFER) && (gidx_q == PW'(gi)) &&
                             req_valid_i[gi] && tx_ready_i;
  end

  // First valid requester at or above ptr, wrapping at N_REQ-1.
  always_comb begin
    int            idx;
    logic [PW-1:0] cand;
    win_found = 1'b0;
    win_idx   = ptr_q;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = PW'(idx);
      if (!win_found && req_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign accept = (state_q == S_XFER) && req_valid_i[gidx_q] && tx_ready_i;

`ifdef UART_ARB_BURST_LIMIT_EN
  localparam int BW = $clog2(MAX_BURST + 1);
  logic [BW-1:0] burst_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_q <= '0;
    end else if (state_q == S_IDLE) begin
      burst_q <= '0;
    end else if (accept) begin
      burst_q <= burst_q + 1'b1;
    end
  end

  assign burst_hit = (burst_q == BW'(MAX_BURST - 1));
`else
  logic unused_max_burst;
  assign unused_max_burst = (MAX_BURST > 0);
  assign burst_hit        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      gidx_q     <= '0;
      grant_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      cfg_q      <= '0;
      cr_q       <= '0;
      holdoff_q  <= '0;
      last_q     <= 1'b0;
    end else begin
      tx_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // The format is latched here so later req_cfg_i changes cannot leak into the burst.
          if (win_found && tx_ready_i && (holdoff_q == 4'd0)) begin
            gidx_q  <= win_idx;
            grant_q <= N_REQ'(1) << win_idx;
            cfg_q   <= cfg_arr[win_idx];
            state_q <= (cfg_arr[win_idx] != cr_q) ? S_CFG : S_XFER;
          end
        end
        S_CFG: begin
          cr_q    <= cfg_q;
          state_q <= S_XFER;
        end
        S_XFER: begin
          if (accept) begin
            tx_data_q  <= data_arr[gidx_q];
            tx_valid_q <= 1'b1;
            holdoff_q  <= 4'(HOLDOFF);
            last_q     <= req_last_i[gidx_q] | burst_hit;
            state_q    <= S_HOLD;
          end
        end
        S_HOLD: begin
          // tx_ready_i is stale until the UART has registered the new frame.
          if (holdoff_q != 4'd0) begin
            holdoff_q <= holdoff_q - 1'b1;
          end else if (tx_ready_i) begin
            state_q <= last_q ? S_RELEASE : S_XFER;
          end
        end
        S_RELEASE: begin
          grant_q <= '0;
          ptr_q   <= (gidx_q == PW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign cr_ptype_o = cr_q[3];
  assign cr_pbit_o  = cr_q[2];
  assign cr_sbit_o  = cr_q[1:0];
  assign grant_o    = grant_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requesters, a lagging UART busy model and a round-robin
// reference that predicts the transmitted byte order, owners and frame formats.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int HO = 2;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [8*N-1:0] req_data_i;
  logic [N-1:0]   req_valid_i;
  logic [N-1:0]   req_last_i;
  logic [4*N-1:0] req_cfg_i;
  logic [N-1:0]   req_ready_o;
  logic [7:0]     tx_data_o;
  logic           tx_valid_o;
  logic           tx_ready_i;
  logic           cr_pbit_o;
  logic [1:0]     cr_sbit_o;
  logic           cr_ptype_o;
  logic [N-1:0]   grant_o;
  logic           busy_o;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .HOLDOFF(HO), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .req_data_i(req_data_i), .req_valid_i(req_valid_i), .req_last_i(req_last_i),
    .req_cfg_i(req_cfg_i), .req_ready_o(req_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .cr_pbit_o(cr_pbit_o), .cr_sbit_o(cr_sbit_o), .cr_ptype_o(cr_ptype_o),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  typedef struct packed {logic [7:0] d; logic last; logic [3:0] cfg;} item_t;
  typedef struct packed {logic [2:0] req; logic [7:0] d; logic [3:0] cfg;} exp_t;

  item_t      rq [N][$];
  exp_t       exp_q [$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         mptr = 0;
  logic [3:0] model_cr = 4'h0;
  bit         gap_en = 1'b0;
  bit         pend = 1'b0;
  int         ucnt = 0;
  logic [N-1:0] rdy_snap = '0;
  logic       val_snap = 1'b0;
  logic [N-1:0] prev_grant = '0;
  logic [3:0] prev_cr = 4'h0;
  bit         lat_track = 1'b0;
  int         lat = 0;
  int         exp_lat = 0;
  int         n_tx = 0;
  string      phase = "init";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] cr_now();
    return {cr_ptype_o, cr_pbit_o, cr_sbit_o};
  endfunction

  task automatic add_burst(input int r, input int n, input logic [7:0] d0,
                           input logic [7:0] step, input logic [3:0] cfg);
    item_t it;
    for (int k = 0; k < n; k++) begin
      it.d    = d0 + 8'(k) * step;
      it.last = (k == n - 1);
      it.cfg  = cfg;
      rq[r].push_back(it);
    end
  endtask

  // Reference: serve whole bursts round-robin from the model pointer.
  task automatic build_expected();
    item_t      wq [N][$];
    item_t      it;
    exp_t       e;
    int         g, cnt;
    bit         done, any;
    logic [3:0] cfg;
    for (int i = 0; i < N; i++) wq[i] = rq[i];
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      for (int i = 0; i < N; i++) if (wq[i].size() != 0) any = 1'b1;
      if (any) begin
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && wq[(mptr + k) % N].size() != 0) g = (mptr + k) % N;
        cfg  = wq[g][0].cfg;
        cnt  = 0;
        done = 1'b0;
        while (!done && wq[g].size() != 0) begin
          it    = wq[g].pop_front();
          cnt++;
          e.req = 3'(g);
          e.d   = it.d;
          e.cfg = cfg;
          exp_q.push_back(e);
          done  = it.last;
`ifdef UART_ARB_BURST_LIMIT_EN
          if (cnt == MB) done = 1'b1;
`endif
        end
        mptr = (g + 1) % N;
      end
    end
  endtask

  task automatic cycle();
    exp_t e;
    @(negedge clk);
    rdy_snap = req_ready_o;
    val_snap = tx_valid_o;
    if (req_ready_o != '0) chk("ready_outside_grant", 32'(req_ready_o & ~grant_o), 32'd0);
    if (lat_track) lat++;
    if (grant_o != '0 && prev_grant == '0 && !reset) begin
      chk("grant_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        chk("grant_owner", 32'(grant_o), 32'd1 << exp_q[0].req);
        exp_lat   = (exp_q[0].cfg != model_cr) ? 2 : 1;
        lat       = 0;
        lat_track = 1'b1;
      end
    end
    if (tx_valid_o) begin
      n_tx++;
      $display("[%0t] %s tx grant=%b data=%02h cfg=%01h", $time, phase, grant_o, tx_data_o, cr_now());
      chk("tx_while_uart_busy", 32'(tx_ready_i), 32'd1);
      chk("tx_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tx_data", 32'(tx_data_o), 32'(e.d));
        chk("tx_grant", 32'(grant_o), 32'd1 << e.req);
        chk("tx_cfg", 32'(cr_now()), 32'(e.cfg));
        if (lat_track) begin
          if (!gap_en) chk("grant_to_tx_latency", 32'(lat), 32'(exp_lat));
          lat_track = 1'b0;
        end
        model_cr = e.cfg;
      end
    end
    if (!reset && cr_now() != prev_cr) chk("cfg_change_uart_idle", 32'(tx_ready_i), 32'd1);
    prev_cr    = cr_now();
    prev_grant = grant_o;

    @(posedge clk);
    #1;
    // UART model registers tx_valid one cycle late, then stays busy for a random frame time.
    if (pend) begin
      ucnt = $urandom_range(3, 10);
      pend = 1'b0;
    end else if (ucnt > 0) begin
      ucnt--;
    end
    if (val_snap) pend = 1'b1;
    tx_ready_i = (ucnt == 0);
    for (int i = 0; i < N; i++)
      if (rdy_snap[i] && rq[i].size() != 0) void'(rq[i].pop_front());
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() != 0) begin
        req_data_i[8*i +: 8] = rq[i][0].d;
        req_last_i[i]        = rq[i][0].last;
        req_cfg_i[4*i +: 4]  = grant_o[i] ? 4'($urandom) : rq[i][0].cfg;
        req_valid_i[i]       = (grant_o[i] && gap_en) ? ($urandom_range(0, 3) != 0) : 1'b1;
      end else begin
        req_data_i[8*i +: 8] = 8'($urandom);
        req_last_i[i]        = 1'($urandom);
        req_cfg_i[4*i +: 4]  = 4'($urandom);
        req_valid_i[i]       = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) rq[i].delete();
    exp_q.delete();
    repeat (3) cycle();
    mptr      = 0;
    model_cr  = 4'h0;
    lat_track = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    chk("rst_tx_data", 32'(tx_data_o), 32'd0);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_cr", 32'(cr_now()), 32'd0);
  endtask

  task automatic run_phase(input string name, input bit gaps, input int budget);
    int c;
    phase  = name;
    gap_en = gaps;
    c      = 0;
    build_expected();
    while ((exp_q.size() != 0 || busy_o) && c < budget) begin
      cycle();
      c++;
    end
    chk("phase_within_budget", 32'(c < budget), 32'd1);
    chk("end_grant", 32'(grant_o), 32'd0);
    chk("end_busy", 32'(busy_o), 32'd0);
  endtask

  initial begin
    int c;
    reset       = 1'b1;
    tx_ready_i  = 1'b1;
    req_data_i  = '0;
    req_valid_i = '0;
    req_last_i  = '0;
    req_cfg_i   = '0;

    phase = "reset";
    do_reset();
    check_reset_outputs();

    add_burst(0, 3, 8'h11, 8'h11, 4'b0000);
    run_phase("single_burst", 1'b0, 200);

    do_reset();
    add_burst(0, 1, 8'hA0, 8'h00, 4'b0000);
    add_burst(0, 1, 8'hA1, 8'h00, 4'b0000);
    add_burst(2, 1, 8'hC0, 8'h00, 4'b0000);
    add_burst(2, 1, 8'hC1, 8'h00, 4'b0000);
    run_phase("alternation", 1'b0, 300);

    add_burst(1, 1, 8'h5A, 8'h00, 4'b1101);
    add_burst(1, 2, 8'h6B, 8'h01, 4'b1101);
    run_phase("cfg_switch", 1'b0, 300);

    add_burst(1, 256, 8'h00, 8'h01, 4'b0110);
    run_phase("byte_sweep", 1'b1, 8000);

    for (int i = 0; i < N; i++)
      for (int b = 0; b < int'($urandom_range(1, 3)); b++)
        add_burst(i, $urandom_range(1, 4), 8'($urandom), 8'($urandom), 4'($urandom));
    run_phase("random_mix", 1'b1, 4000);

    do_reset();
    add_burst(0, 10, 8'h30, 8'h01, 4'b0000);
    add_burst(3, 2, 8'hE0, 8'h01, 4'b0000);
    run_phase("burst_limit", 1'b0, 1500);

    add_burst(2, 1, 8'h77, 8'h00, 4'b0000);
    run_phase("ptr_to_3", 1'b0, 200);

    phase  = "midburst_reset";
    gap_en = 1'b0;
    add_burst(2, 5, 8'h90, 8'h01, 4'b0000);
    build_expected();
    n_tx = 0;
    c    = 0;
    while (n_tx < 2 && c < 300) begin
      cycle();
      c++;
    end
    chk("two_bytes_within_budget", 32'(c < 300), 32'd1);
    reset = 1'b1;
    for (int i = 0; i < N; i++) rq[i].delete();
    exp_q.delete();
    cycle();
    chk("mid_tx_valid", 32'(tx_valid_o), 32'd0);
    chk("mid_grant", 32'(grant_o), 32'd0);
    chk("mid_ready", 32'(req_ready_o), 32'd0);
    chk("mid_busy", 32'(busy_o), 32'd0);
    repeat (2) cycle();
    mptr      = 0;
    model_cr  = 4'h0;
    lat_track = 1'b0;
    reset     = 1'b0;
    repeat (30) cycle();

    add_burst(0, 1, 8'h01, 8'h00, 4'b0000);
    add_burst(3, 1, 8'h03, 8'h00, 4'b0000);
    run_phase("ptr_after_reset", 1'b0, 300);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
